fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction fetch stage for the CE-4301 pipeline: owns the PC register, a programmable instruction store, jump pre-decode and end-of-program halt. It replaces the combinational instruction memory with a registered fetch stage that adds stall, branch redirect/flush and a load port. Outputs feed the decode stage directly: a registered instruction word plus its decoded field slices.

## Interface
- DATA_W, 32: instruction width; field positions below assume 32.
- DEPTH, 64: instruction store depth in words.
- PC_W, 32: PC width; PC counts words, not bytes.
- NOP_WORD, 32'hF800_0000: word injected on reset, flush, halt and out-of-range fetch.
- END_WORD, 32'hFFFF_FFFF: end-of-program sentinel.
- J_OPCODE, 5'd16: opcode of unconditional jump.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold PC and instruction register.
- redirect_valid  in  1  branch taken in a later stage; squash and reload PC.
- redirect_pc  in  PC_W  branch target.
- prog_we  in  1  instruction store write enable.
- prog_addr  in  clog2(DEPTH)  store write address.
- prog_data  in  DATA_W  store write data.
- pc  out  PC_W  current fetch address.
- instr  out  DATA_W  registered fetched word.
- instr_pc  out  PC_W  address that instr came from.
- opcode  out  5  instr[31:27].
- rd  out  5  instr[26:22].
- rs  out  5  instr[21:17].
- rt  out  5  instr[16:12].
- imm  out  17  instr[16:0].
- jaddr  out  PC_W  instr[26:0] zero-extended (truncated if PC_W<27).
- halted  out  1  sticky, END_WORD fetched.
- addr_err  out  1  sticky, fetch attempted with pc >= DEPTH.

## Operation
- Reset values: pc=0, instr=NOP_WORD, instr_pc=0, halted=0, addr_err=0. Store contents not cleared by rst.
- Field outputs are combinational slices of instr; no separate state.
- Fetch word w = mem[pc] if pc < DEPTH, else NOP_WORD (and addr_err set that edge).
- Per edge, priority order (highest first):
  - rst: reset values.
  - halted: everything frozen; redirect and stall ignored.
  - redirect_valid: pc<=redirect_pc; instr<=NOP_WORD; instr_pc<=pc. Overrides stall.
  - stall: pc, instr, instr_pc hold.
  - w==END_WORD: halted<=1; instr<=NOP_WORD; pc holds.
  - w[31:27]==J_OPCODE: instr<=w; instr_pc<=pc; pc<=w[26:0] zero-extended/truncated.
  - else: instr<=w; instr_pc<=pc; pc<=pc+1 modulo 2^PC_W.
- Store write: synchronous on prog_we, any time (including while halted). Same-cycle read of written address returns old data.
- addr_err updates only on an edge that actually fetches (not stalled, not halted, no redirect).

## Timing
- Fetch latency 1 cycle: pc=p sampled at edge N -> instr=mem[p] after edge N.
- Jump penalty 0: target fetched on the edge after the jump is fetched.
- Redirect: one NOP bubble; target instruction on instr 2 edges after redirect asserted.
- Halt: takes effect the edge END_WORD is fetched; from then instr=NOP_WORD until rst.
- rst mid-stall/mid-redirect: rst wins; pc=0 next cycle.
- Wrap: pc=2^PC_W-1 -> 0 (addr_err set earlier since DEPTH < 2^PC_W).

## Test plan
- Reset then load mem[0..3]=ADDI words, mem[4]=END_WORD, run -> instr sequence NOP, mem[0..3], then NOP forever; halted=1 after 6th edge; pc holds 4.
- mem[2]=32'h8000_000A (J 10), mem[10]=ADDI -> instr_pc sequence 0,1,2,10,11; no bubble.
- Assert stall 3 cycles while pc=5 -> pc, instr, instr_pc unchanged for 3 edges; resumes at 5.
- stall=1 and redirect_valid=1 with redirect_pc=20 at pc=7 -> next instr=NOP_WORD, pc=20; mem[20] appears one edge later.
- Redirect to pc=DEPTH (64) -> instr=NOP_WORD, addr_err=1 after fetch edge, stays 1 until rst.
- prog_we to address pc in same cycle as fetch -> instr gets old word; next fetch of that address gets new word; rst mid-run -> pc=0, halted=0, store retained.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: registered instruction fetch stage with a programmable store,
// zero-penalty jump pre-decode, branch redirect/flush, stall and END halt.
module fetch_unit #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 64,
  parameter int unsigned       PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hF800_0000,
  parameter logic [DATA_W-1:0] END_WORD = 32'hFFFF_FFFF,
  parameter logic [4:0]        J_OPCODE = 5'd16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [PC_W-1:0]          pc,
  output logic [DATA_W-1:0]        instr,
  output logic [PC_W-1:0]          instr_pc,
  output logic [4:0]               opcode,
  output logic [4:0]               rd,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [16:0]              imm,
  output logic [PC_W-1:0]          jaddr,
  output logic                     halted,
  output logic                     addr_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range_c;
  logic [DATA_W-1:0] word_c;
  logic [PC_W-1:0]   pc_n;
  logic [DATA_W-1:0] instr_n;
  logic [PC_W-1:0]   instr_pc_n;
  logic              halted_n;
  logic              addr_err_n;

  // Instruction store: write-only port, old data visible to a same-edge fetch
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Next-state selection in priority order: halt, redirect, stall, fetch
  always_comb begin
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    halted_n   = halted;
    addr_err_n = addr_err;
    in_range_c = (64'(pc) < 64'(DEPTH));
    word_c     = in_range_c ? mem[AW'(pc)] : NOP_WORD;

    if (halted) begin
      // frozen until reset
    end else if (redirect_valid) begin
      pc_n       = redirect_pc;
      instr_n    = NOP_WORD;
      instr_pc_n = pc;
    end else if (stall) begin
      // hold
    end else begin
      addr_err_n = addr_err | ~in_range_c;
      if (word_c == END_WORD) begin
        halted_n = 1'b1;
        instr_n  = NOP_WORD;
      end else begin
        instr_n    = word_c;
        instr_pc_n = pc;
        if (word_c[31:27] == J_OPCODE) begin
          pc_n = PC_W'(word_c[26:0]);
        end else begin
          pc_n = pc + PC_W'(1);
        end
      end
    end
  end

  // Fetch state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      instr    <= NOP_WORD;
      instr_pc <= '0;
      halted   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      pc       <= pc_n;
      instr    <= instr_n;
      instr_pc <= instr_pc_n;
      halted   <= halted_n;
      addr_err <= addr_err_n;
    end
  end

  // Decode field slices of the registered word
  always_comb begin
    opcode = instr[31:27];
    rd     = instr[26:22];
    rs     = instr[21:17];
    rt     = instr[16:12];
    imm    = instr[16:0];
    jaddr  = PC_W'(instr[26:0]);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a per-cycle reference model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'hF800_0000;
  localparam logic [31:0] ENDW  = 32'hFFFF_FFFF;
  localparam logic [31:0] NEWW  = 32'h0A00_1234;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [16:0] imm;
  logic [31:0] jaddr;
  logic        halted;
  logic        addr_err;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .jaddr(jaddr),
    .halted(halted), .addr_err(addr_err)
  );

  // Reference model state
  logic [31:0] mm [DEPTH];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_halt;
  logic        m_err;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Filler ADDI-style word: opcode 1, rd=i, rs=2, imm=i
  function automatic logic [31:0] fill(input int i);
    logic [31:0] w;
    w = {5'd1, 5'(i), 5'd2, 17'(i)};
    return w;
  endfunction

  // Behaviour of one rising edge, applied to the model
  task automatic model_edge();
    logic [31:0] w;
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_ipc = 0; m_halt = 1'b0; m_err = 1'b0;
    end else if (!m_halt) begin
      if (redirect_valid) begin
        m_ipc = m_pc; m_pc = redirect_pc; m_instr = NOP;
      end else if (!stall) begin
        if (m_pc < DEPTH) w = mm[m_pc[5:0]];
        else begin w = NOP; m_err = 1'b1; end
        if (w == ENDW) begin
          m_halt = 1'b1; m_instr = NOP;
        end else begin
          m_instr = w; m_ipc = m_pc;
          m_pc = (w[31:27] == 5'd16) ? {5'b0, w[26:0]} : m_pc + 1;
        end
      end
    end
    if (prog_we) mm[prog_addr] = prog_data;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = 6'(a); prog_data = d;
    cycle();
    prog_we = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("instr", instr, m_instr);
      if (!m_halt) chk("instr_pc", instr_pc, m_ipc);
      chk("halted", halted, m_halt);
      chk("addr_err", addr_err, m_err);
      chk("opcode", opcode, m_instr[31:27]);
      chk("rd", rd, m_instr[26:22]);
      chk("rs", rs, m_instr[21:17]);
      chk("rt", rt, m_instr[16:12]);
      chk("imm", imm, m_instr[16:0]);
      chk("jaddr", jaddr, {5'b0, m_instr[26:0]});
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    cycle();
    chk_en = 1'b1;
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_halted", halted, 0);
    chk("rst_addr_err", addr_err, 0);
    for (int i = 0; i < DEPTH; i++) load(i, fill(i));
    load(4, ENDW);

    // Straight-line program ending in END
    rst = 1'b0;
    run(4);
    chk("seq_instr3", instr, 32'h08C4_0003);
    chk("seq_ipc3", instr_pc, 3);
    chk("seq_pc4", pc, 4);
    cycle();
    chk("halt_set", halted, 1);
    chk("halt_nop", instr, NOP);
    chk("halt_pc", pc, 4);
    redirect_valid = 1'b1; redirect_pc = 32'd9; stall = 1'b1;
    run(2);
    redirect_valid = 1'b0; stall = 1'b0;
    chk("halt_frozen_pc", pc, 4);
    load(4, fill(4));
    chk("halt_still", halted, 1);

    // Jump with zero penalty
    rst = 1'b1;
    load(2, 32'h8000_000A);
    rst = 1'b0;
    chk("rst_clears_halt", halted, 0);
    cycle(); chk("j_ipc0", instr_pc, 0);
    cycle(); chk("j_ipc1", instr_pc, 1);
    cycle(); chk("j_ipc2", instr_pc, 2);
    chk("j_opcode", opcode, 16);
    chk("j_jaddr", jaddr, 10);
    chk("j_pc", pc, 10);
    cycle(); chk("j_ipc10", instr_pc, 10);
    chk("j_instr10", instr, 32'h0A84_000A);
    cycle(); chk("j_ipc11", instr_pc, 11);

    // Stall at pc=5
    rst = 1'b1;
    load(2, fill(2));
    rst = 1'b0;
    run(5);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_pc", pc, 5);
      chk("stall_ipc", instr_pc, 4);
      chk("stall_instr", instr, 32'h0904_0004);
    end
    stall = 1'b0;
    cycle();
    chk("resume_ipc", instr_pc, 5);

    // Redirect overrides stall
    cycle();
    chk("pre_redir_pc", pc, 7);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd20;
    cycle();
    stall = 1'b0; redirect_valid = 1'b0;
    chk("redir_nop", instr, NOP);
    chk("redir_pc", pc, 20);
    chk("redir_ipc", instr_pc, 7);
    cycle();
    chk("redir_target", instr, 32'h0D04_0014);
    chk("redir_target_ipc", instr_pc, 20);

    // Out-of-range fetch and PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'd64;
    cycle();
    redirect_valid = 1'b0;
    chk("oor_no_err_yet", addr_err, 0);
    cycle();
    chk("oor_err", addr_err, 1);
    chk("oor_nop", instr, NOP);
    chk("oor_pc", pc, 65);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("err_sticky", addr_err, 1);
    chk("err_instr0", instr, 32'h0804_0000);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("wrap_pc", pc, 0);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFF);

    // Write during fetch of same address, then reset mid-redirect
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_clears_err", addr_err, 0);
    run(3);
    load(3, NEWW);
    chk("wr_old_word", instr, 32'h08C4_0003);
    redirect_valid = 1'b1; redirect_pc = 32'd3;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("wr_new_word", instr, NEWW);
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd30;
    cycle();
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    chk("rst_wins_pc", pc, 0);
    chk("rst_wins_instr", instr, NOP);
    run(4);
    chk("store_kept", instr, NEWW);
    chk("store_kept_ipc", instr_pc, 3);

    chk_en = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
